// File: rtl/datamover_sched_package.sv
// ---------------------------------------------------------------------------
// datamover_sched_package
// Shared types for the datamover job scheduler.
//   job_t          : one transfer descriptor (source, sink, length, tag)
//   sched_state_e  : scheduler FSM encoding
//   queue_count_w  : width of an occupancy counter for a given queue depth
// ---------------------------------------------------------------------------
package datamover_sched_package;

    // Width of the tag stored in a queued descriptor. The scheduler's ID_W
    // parameter is expected to match this value.
    localparam int unsigned JOB_ID_W = 4;

    // Default queue depth and the matching occupancy counter width.
    localparam int unsigned DEFAULT_QUEUE_DEPTH = 4;
    localparam int unsigned DEFAULT_COUNT_W     = $clog2(DEFAULT_QUEUE_DEPTH) + 1;

    typedef struct packed {
        logic [31:0]         src_addr;
        logic [31:0]         dst_addr;
        logic [31:0]         len;
        logic [JOB_ID_W-1:0] id;
    } job_t;

    // Explicit encodings keep the state values stable for register maps and
    // external checkers.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_WORK   = 3'd2,
        ST_FINISH = 3'd3,
        ST_SKIP   = 3'd4
    } sched_state_e;

    // An occupancy counter must represent 0..depth inclusive.
    function automatic int unsigned queue_count_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/datamover_job_fifo.sv
// ---------------------------------------------------------------------------
// datamover_job_fifo
// Descriptor queue for the job scheduler: DEPTH entries of job_t, first-word
// fall-through head, synchronous active-low reset and synchronous clear.
// Ports:
//   clk, rst_n, clear   : clock, sync active-low reset, sync soft clear
//   push, push_data     : write request (ignored while full) and descriptor
//   pop                 : release the head entry (ignored while empty)
//   head                : oldest entry, valid whenever empty is low
//   count, full, empty  : registered occupancy and derived flags
// ---------------------------------------------------------------------------
module datamover_job_fifo
    import datamover_sched_package::*;
#(
    parameter int unsigned DEPTH = DEFAULT_QUEUE_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  push,
    input  job_t                  push_data,
    input  logic                  pop,
    output job_t                  head,
    output logic [$clog2(DEPTH):0] count,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CW    = queue_count_w(DEPTH);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    job_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Full/empty come from the registered count only, so a pop in the same
    // cycle never makes room for a push.
    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read while count says valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/datamover_job_sched.sv
// ---------------------------------------------------------------------------
// datamover_job_sched
// Job-queue controller for the datamover streamers. Descriptors are queued,
// launched one at a time with a synchronised start to source and sink, and
// retired with a done event carrying the job id and its cycle count.
// Ports:
//   clk_i, rst_ni, clear_i       : clock, sync active-low reset, soft clear
//   job_*_i, job_ready_o         : descriptor push interface
//   src/dst_base_addr_o, tot_len_o : config for the address generators
//   src/sink_req_start_o         : start pulse pair (always together)
//   src/sink_ready_start_i       : streamers able to accept a start
//   src/sink_done_i              : streamer completion pulses
//   tcdm_fifo_empty_i            : TCDM FIFO drained
//   busy_o                       : job active or queue non-empty
//   evt_done_o / evt_err_o       : job complete / zero-length job skipped
//   done_id_o, done_cycles_o     : last retired id / last job duration
//   queue_count_o                : queued descriptors
//
// Push handshake: a descriptor is taken on a rising clock edge where
// job_valid_i and job_ready_o are both high. job_ready_o depends only on the
// registered queue occupancy, never on job_valid_i or on a same-cycle pop;
// the host may hold job_valid_i and the descriptor until it is taken.
// ---------------------------------------------------------------------------
module datamover_job_sched
    import datamover_sched_package::*;
#(
    parameter int unsigned QUEUE_DEPTH = DEFAULT_QUEUE_DEPTH,
    parameter int unsigned ID_W        = JOB_ID_W,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clear_i,
    input  logic                         job_valid_i,
    output logic                         job_ready_o,
    input  logic [31:0]                  job_src_addr_i,
    input  logic [31:0]                  job_dst_addr_i,
    input  logic [31:0]                  job_len_i,
    input  logic [ID_W-1:0]              job_id_i,
    output logic [31:0]                  src_base_addr_o,
    output logic [31:0]                  dst_base_addr_o,
    output logic [31:0]                  tot_len_o,
    output logic                         src_req_start_o,
    output logic                         sink_req_start_o,
    input  logic                         src_ready_start_i,
    input  logic                         src_done_i,
    input  logic                         sink_ready_start_i,
    input  logic                         sink_done_i,
    input  logic                         tcdm_fifo_empty_i,
    output logic                         busy_o,
    output logic                         evt_done_o,
    output logic                         evt_err_o,
    output logic [ID_W-1:0]              done_id_o,
    output logic [CNT_W-1:0]             done_cycles_o,
    output logic [$clog2(QUEUE_DEPTH):0] queue_count_o
);

    sched_state_e                 state;
    sched_state_e                 state_next;
    job_t                         push_job;
    job_t                         head;
    logic                         q_full;
    logic                         q_empty;
    logic                         q_pop;
    logic [$clog2(QUEUE_DEPTH):0] q_count;

    logic                         fire;
    logic                         latch_done;
    logic                         src_flag;
    logic                         sink_flag;
    logic                         src_seen;
    logic                         sink_seen;
    logic                         work_done;
    logic                         run_next;

    logic [CNT_W-1:0]             cnt;
    logic [CNT_W-1:0]             cnt_inc;
    logic [31:0]                  src_base;
    logic [31:0]                  dst_base;
    logic [31:0]                  tot_len;
    logic [ID_W-1:0]              done_id_q;
    logic [CNT_W-1:0]             done_cycles_q;

    always_comb begin
        push_job          = '0;
        push_job.src_addr = job_src_addr_i;
        push_job.dst_addr = job_dst_addr_i;
        push_job.len      = job_len_i;
        push_job.id       = JOB_ID_W'(job_id_i);
    end

    datamover_job_fifo #(
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .clear     (clear_i),
        .push      (job_valid_i),
        .push_data (push_job),
        .pop       (q_pop),
        .head      (head),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    // The head entry is released only once its job has been retired.
    assign q_pop = (state == ST_FINISH) || (state == ST_SKIP);

    // Both streamers are started in the same cycle, and only when both can
    // accept; a lone start would desynchronise source and sink.
    assign fire = (state == ST_START) && src_ready_start_i && sink_ready_start_i;

    // Done pulses count from the start cycle on; a done coinciding with the
    // start pulse must not be lost.
    assign latch_done = fire || (state == ST_WORK);
    assign src_seen   = src_flag | src_done_i;
    assign sink_seen  = sink_flag | sink_done_i;
    assign work_done  = src_seen && sink_seen && tcdm_fifo_empty_i;

    assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (!q_empty) begin
                    state_next = (head.len == '0) ? ST_SKIP : ST_START;
                end
            end
            ST_START:  if (fire) state_next = ST_WORK;
            ST_WORK:   if (work_done) state_next = ST_FINISH;
            ST_FINISH: state_next = ST_IDLE;
            ST_SKIP:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Config registers follow the state they will be visible in, so they
    // carry the head descriptor exactly while the job is in START/WORK.
    assign run_next = (state_next == ST_START) || (state_next == ST_WORK);

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            state         <= ST_IDLE;
            src_flag      <= 1'b0;
            sink_flag     <= 1'b0;
            cnt           <= '0;
            src_base      <= '0;
            dst_base      <= '0;
            tot_len       <= '0;
            done_id_q     <= '0;
            done_cycles_q <= '0;
        end else begin
            state <= state_next;

            // The START cycle itself counts as cycle 1.
            if ((state == ST_IDLE) && (state_next == ST_START)) begin
                cnt <= CNT_W'(1);
            end else if ((state == ST_START) || (state == ST_WORK)) begin
                cnt <= cnt_inc;
            end

            if (run_next) begin
                src_base <= head.src_addr;
                dst_base <= head.dst_addr;
                tot_len  <= head.len;
            end else begin
                src_base <= '0;
                dst_base <= '0;
                tot_len  <= '0;
            end

            if (state == ST_FINISH) begin
                src_flag  <= 1'b0;
                sink_flag <= 1'b0;
            end else if (latch_done) begin
                src_flag  <= src_seen;
                sink_flag <= sink_seen;
            end

            if (state == ST_FINISH) begin
                done_id_q     <= ID_W'(head.id);
                done_cycles_q <= cnt;
            end else if (state == ST_SKIP) begin
                done_id_q <= ID_W'(head.id);
            end
        end
    end

    assign job_ready_o      = ~q_full;
    assign queue_count_o    = q_count;
    assign src_req_start_o  = fire;
    assign sink_req_start_o = fire;
    assign src_base_addr_o  = src_base;
    assign dst_base_addr_o  = dst_base;
    assign tot_len_o        = tot_len;
    assign busy_o           = (state != ST_IDLE) || !q_empty;
    assign evt_done_o       = (state == ST_FINISH);
    assign evt_err_o        = (state == ST_SKIP);

    // Id and duration are presented together with the event pulse and held
    // afterwards until the next retirement.
    assign done_id_o     = ((state == ST_FINISH) || (state == ST_SKIP)) ? ID_W'(head.id) : done_id_q;
    assign done_cycles_o = (state == ST_FINISH) ? cnt : done_cycles_q;

endmodule

// File: doc/datamover_job_sched.md
Name: datamover_job_sched

Overview:
Job-queue controller that sequences the datamover's source and sink streamers.
- Software or a host pushes transfer descriptors (src, dst, length, id) into a small queue.
- The block launches one descriptor at a time: drives the base/length config, issues a synchronised req_start to both streamers, and waits for completion (both streams done and TCDM FIFO drained).
- It then emits a done event with the job id and that job's cycle count.
- It sits between the control slave/register file and the streamer, replacing the minimal single-shot start FSM.

Parameters:
- QUEUE_DEPTH, 4, descriptor queue entries (power of two, ≥2)
- ID_W, 4, job id width
- CNT_W, 32, per-job cycle counter width (saturating)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- clear_i  in  1  synchronous soft clear
- job_valid_i  in  1  descriptor push request
- job_ready_o  out  1  queue can accept (= not full)
- job_src_addr_i  in  32  source base address
- job_dst_addr_i  in  32  sink base address
- job_len_i  in  32  total length in words
- job_id_i  in  ID_W  job tag
- src_base_addr_o  out  32  to source addressgen
- dst_base_addr_o  out  32  to sink addressgen
- tot_len_o  out  32  to both addressgens
- src_req_start_o  out  1  source start pulse
- sink_req_start_o  out  1  sink start pulse
- src_ready_start_i  in  1  source can start
- src_done_i  in  1  source done pulse
- sink_ready_start_i  in  1  sink can start
- sink_done_i  in  1  sink done pulse
- tcdm_fifo_empty_i  in  1  TCDM FIFO drained
- busy_o  out  1  state != IDLE or queue non-empty
- evt_done_o  out  1  one-cycle job-complete pulse
- evt_err_o  out  1  one-cycle pulse, zero-length job skipped
- done_id_o  out  ID_W  id of completed job, held until next completion
- done_cycles_o  out  CNT_W  cycles START→FINISH of last job, held
- queue_count_o  out  $clog2(QUEUE_DEPTH)+1  occupied entries

Behaviour:
- Reset is synchronous active-low on clk_i. Reset and clear_i have identical effect:
  - state IDLE, queue empty
  - all outputs 0 (job_ready_o=1)
  - sticky done flags and counter cleared
- Reset has priority over clear_i.
- Queue push:
  - Push when job_valid_i & job_ready_o.
  - job_ready_o depends only on the registered count; no bypass.
  - A push and a pop in the same cycle are legal when not full; count is unchanged.
  - When full, job_ready_o=0 even if a pop happens this cycle.
- Config outputs (src/dst/tot_len):
  - Driven from the head entry while state ∈ {START, WORK}; 0 otherwise.
  - Registered, stable for the whole job.
- FSM states: IDLE, START, WORK, FINISH, SKIP.
  - IDLE: if queue non-empty: head len==0 → SKIP, else → START. A job pushed at cycle t is visible at t+1 and leaves IDLE at t+1 (START at t+2).
  - START: src_req_start_o and sink_req_start_o are asserted together, combinationally, only in cycles where src_ready_start_i & sink_ready_start_i. They are never asserted individually. In the asserting cycle → WORK; otherwise stay. Cycle counter is reset to 1 on START entry and increments every cycle through WORK (saturates at all-ones).
  - WORK: src_done_i/sink_done_i are latched into sticky flags (a done in the same cycle as the req_start is also latched). When both flags are set (or their inputs are high this cycle) and tcdm_fifo_empty_i → FINISH.
  - FINISH (1 cycle): evt_done_o=1; update done_id_o and done_cycles_o; pop head; clear sticky flags → IDLE.
  - SKIP (1 cycle): evt_err_o=1; update done_id_o; pop; done_cycles_o unchanged; no req_start → IDLE.
- Back-to-back jobs: minimum gap of FINISH→IDLE→START, i.e. 2 cycles between evt_done_o and the next req_start.
- clear_i mid-job (START/WORK): abort without an event; queue flushed. The streamers' own clear is handled externally.
- Done pulses arriving in IDLE/START/FINISH/SKIP are ignored.

Decomposition:
- Package datamover_sched_package:
  - job_t packed struct {src_addr, dst_addr, len, id}
  - sched_state_e enum
  - localparam for count width
- Sub-module datamover_job_fifo:
  - QUEUE_DEPTH × job_t, sync reset/clear
  - push/pop, head, count, full/empty
- The FSM, sticky flags, counter and output registers live in the top.

Test Plan:
1. Single job (src=0x100, dst=0x800, len=16, id=3), both ready_start=1; sink_done 5 cycles after start, src_done 2 cycles after start, fifo_empty=1 → exactly one req_start pair, evt_done_o once, done_id_o=3, done_cycles_o=7.
2. ready_start withheld: src_ready_start_i=1, sink_ready_start_i=0 for 4 cycles → no req_start on either output until both high; then both start pulses occur in the same cycle.
3. Fill the queue with 4 jobs (ids 0..3) → job_ready_o=0 and queue_count_o=4; a 5th push is stalled. Completions are in order 0,1,2,3, and job_ready_o rises the cycle after the first pop.
4. Zero-length job (id=5) between two normal jobs → evt_err_o pulse with done_id_o=5, no req_start for it, and the neighbours complete normally.
5. Both dones seen but tcdm_fifo_empty_i=0 for 3 cycles → FINISH waits; evt_done_o fires the cycle after tcdm_fifo_empty_i rises.
6. clear_i asserted in WORK with 2 jobs queued → no evt, busy_o=0 and queue_count_o=0 next cycle. A subsequent push runs normally with its done_cycles_o counted from 1.
